// File: rtl/wfg_subcore_multi.sv
`default_nettype none
// ============================================================================
// Module  : wfg_subcore_multi
// Brief   : Subcycle/sync timing generator with CHANNELS phase-offset sync
//           outputs, burst mode and a Wishbone register file.
// Revision: 1.0
// ============================================================================
module wfg_subcore_multi #(
  parameter int BUSW     = 32,
  parameter int SUBW     = 16,
  parameter int SYNCW    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [BUSW/8-1:0]   wbs_sel_i,
  input  logic [BUSW-1:0]     wbs_dat_i,
  input  logic [BUSW-1:0]     wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [BUSW-1:0]     wbs_dat_o,
  output logic                wfg_subcore_subcycle_o,
  output logic [CHANNELS-1:0] wfg_subcore_sync_o,
  output logic                wfg_subcore_start_o,
  output logic [SYNCW-1:0]    wfg_subcore_subcycle_cnt_o,
  output logic                active_o,
  output logic                done_o
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [3:0] A_CTRL   = 4'd0;
  localparam logic [3:0] A_SUB    = 4'd1;
  localparam logic [3:0] A_SYNC   = 4'd2;
  localparam logic [3:0] A_BURST  = 4'd3;
  localparam logic [3:0] A_STATUS = 4'd4;

  logic             ack_q;
  logic [BUSW-1:0]  dat_q;
  logic             en_q, mode_cfg_q;
  logic [SUBW-1:0]  sub_thr_q;
  logic [SYNCW-1:0] sync_thr_q;
  logic [15:0]      burst_cfg_q;
  logic [SYNCW-1:0] offset_q [CHANNELS];

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic             start_q, start_d;
  logic             en_prev_q;
  logic [SUBW-1:0]  sub_q, sub_d;
  logic [SYNCW-1:0] sync_q, sync_d;
  logic [15:0]      per_q, per_d;
  logic             mode_q, mode_d;
  logic [15:0]      bcnt_q, bcnt_d;

  logic             w_acc, w_wr, w_clr, w_start, w_active, w_sub_pulse, w_wrap;
  logic [3:0]       w_idx;
  logic [BUSW-1:0]  w_mask, w_rd_data;
  logic [15:0]      w_bgoal;
  logic [16:0]      w_per_inc;
  logic             unused_ok;

  assign w_acc   = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign w_wr    = w_acc & wbs_we_i;
  assign w_idx   = wbs_adr_i[5:2];
  assign w_clr   = w_wr & (w_idx == A_CTRL) & wbs_sel_i[0] & wbs_dat_i[2];
  assign unused_ok = ^{wbs_adr_i, wbs_dat_i, w_mask};

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < BUSW / 8; b++) w_mask[8*b +: 8] = {8{wbs_sel_i[b]}};
  end

  always_comb begin
    w_rd_data = '0;
    case (w_idx)
      A_CTRL:   w_rd_data[1:0] = {mode_cfg_q, en_q};
      A_SUB:    w_rd_data[SUBW-1:0] = sub_thr_q;
      A_SYNC:   w_rd_data[SYNCW-1:0] = sync_thr_q;
      A_BURST:  w_rd_data[15:0] = burst_cfg_q;
      A_STATUS: begin
        w_rd_data[0]     = (state_q == ST_RUN);
        w_rd_data[1]     = done_q;
        w_rd_data[31:16] = per_q;
      end
      default: begin
        for (int k = 0; k < CHANNELS; k++)
          if (w_idx == 4'(8 + k)) w_rd_data[SYNCW-1:0] = offset_q[k];
      end
    endcase
  end

  // Register file: the write lands on the same edge that raises ack.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      en_q        <= 1'b0;
      mode_cfg_q  <= 1'b0;
      sub_thr_q   <= '0;
      sync_thr_q  <= '0;
      burst_cfg_q <= '0;
      for (int k = 0; k < CHANNELS; k++) offset_q[k] <= '0;
    end else begin
      ack_q <= w_acc;
      dat_q <= (w_acc & ~wbs_we_i) ? w_rd_data : '0;
      if (w_wr) begin
        case (w_idx)
          A_CTRL: if (wbs_sel_i[0]) begin
            en_q       <= wbs_dat_i[0];
            mode_cfg_q <= wbs_dat_i[1];
          end
          A_SUB:   sub_thr_q   <= (sub_thr_q & ~w_mask[SUBW-1:0]) | (wbs_dat_i[SUBW-1:0] & w_mask[SUBW-1:0]);
          A_SYNC:  sync_thr_q  <= (sync_thr_q & ~w_mask[SYNCW-1:0]) | (wbs_dat_i[SYNCW-1:0] & w_mask[SYNCW-1:0]);
          A_BURST: burst_cfg_q <= (burst_cfg_q & ~w_mask[15:0]) | (wbs_dat_i[15:0] & w_mask[15:0]);
          default: begin
            for (int k = 0; k < CHANNELS; k++)
              if (w_idx == 4'(8 + k))
                offset_q[k] <= (offset_q[k] & ~w_mask[SYNCW-1:0]) | (wbs_dat_i[SYNCW-1:0] & w_mask[SYNCW-1:0]);
          end
        endcase
      end
    end
  end

  assign w_active    = (state_q == ST_RUN);
  assign w_start     = en_q & ~en_prev_q & ~w_active;
  assign w_sub_pulse = w_active & (sub_q >= sub_thr_q);
  assign w_wrap      = (sync_q >= sync_thr_q);
  assign w_bgoal     = (bcnt_q == 16'd0) ? 16'd1 : bcnt_q;
  assign w_per_inc   = {1'b0, per_q} + 17'd1;

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    start_d = 1'b0;
    sub_d   = sub_q;
    sync_d  = sync_q;
    per_d   = per_q;
    mode_d  = mode_q;
    bcnt_d  = bcnt_q;
    if (w_clr) done_d = 1'b0;
    if (w_start) begin
      state_d = ST_RUN;
      start_d = 1'b1;
      sub_d   = '0;
      sync_d  = '0;
      per_d   = '0;
      done_d  = 1'b0;
      mode_d  = mode_cfg_q;
      bcnt_d  = burst_cfg_q;
    end else if (w_active) begin
      if (!en_q) begin
        state_d = ST_IDLE;
        sub_d   = '0;
        sync_d  = '0;
      end else begin
        sub_d = w_sub_pulse ? '0 : sub_q + SUBW'(1);
        if (w_sub_pulse) sync_d = w_wrap ? '0 : sync_q + SYNCW'(1);
        if (w_sub_pulse && w_wrap) begin
          if (mode_q) begin
            per_d = w_per_inc[15:0];
            if (w_per_inc >= {1'b0, w_bgoal}) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              sub_d   = '0;
              sync_d  = '0;
            end
          end else if (per_q != 16'hFFFF) begin
            per_d = w_per_inc[15:0];
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      en_prev_q <= 1'b0;
      sub_q     <= '0;
      sync_q    <= '0;
      per_q     <= '0;
      mode_q    <= 1'b0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      start_q   <= start_d;
      en_prev_q <= en_q;
      sub_q     <= sub_d;
      sync_q    <= sync_d;
      per_q     <= per_d;
      mode_q    <= mode_d;
      bcnt_q    <= bcnt_d;
    end
  end

  genvar gk;
  generate
    for (gk = 0; gk < CHANNELS; gk++) begin : g_sync
      assign wfg_subcore_sync_o[gk] = w_sub_pulse & (sync_q == offset_q[gk]);
    end
  endgenerate

  assign wbs_ack_o                  = ack_q;
  assign wbs_dat_o                  = dat_q;
  assign wfg_subcore_subcycle_o     = w_sub_pulse;
  assign wfg_subcore_start_o        = start_q;
  assign wfg_subcore_subcycle_cnt_o = sync_q;
  assign active_o                   = w_active;
  assign done_o                     = done_q;

endmodule
`default_nettype wire

// File: doc/wfg_subcore_multi.md
# wfg_subcore_multi

Second-generation subcore timing generator with an integrated Wishbone register file. It produces one subcycle pulse train, a subcycle counter, and `CHANNELS` independent sync pulse outputs, each with a programmable phase offset. It runs in continuous mode or in burst mode, where it stops after a programmed number of sync periods and sets a sticky done flag. It drives the same downstream consumers as the existing subcore: drivers and stimulus cores.

## Interface
- `BUSW`, 32: Wishbone data and address width.
- `SUBW`, 16: subcycle counter and threshold width, 1..24.
- `SYNCW`, 8: sync counter, threshold and offset width, 1..16.
- `CHANNELS`, 4: number of sync outputs, 1..8.
- `wb_clk_i` in 1: single clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1: Wishbone strobe, cycle and write enable.
- `wbs_sel_i` in BUSW/8: byte enables.
- `wbs_dat_i` in BUSW: write data.
- `wbs_adr_i` in BUSW: byte address. Only bits [5:2] are decoded.
- `wbs_ack_o` out 1: acknowledge.
- `wbs_dat_o` out BUSW: read data.
- `wfg_subcore_subcycle_o` out 1: subcycle pulse.
- `wfg_subcore_sync_o` out CHANNELS: per-channel sync pulse.
- `wfg_subcore_start_o` out 1: one-cycle start pulse.
- `wfg_subcore_subcycle_cnt_o` out SYNCW: current sync counter value.
- `active_o` out 1: generator running.
- `done_o` out 1: sticky burst-complete flag.

## Operation
- Register map, all registers reset to 0:
  - 0x00 CTRL: bit0 EN, bit1 MODE (0 = continuous, 1 = burst), bit2 CLR_DONE (write-1, self-clearing, reads 0).
  - 0x04 CFG_SUB: [SUBW-1:0] subcycle threshold S.
  - 0x08 CFG_SYNC: [SYNCW-1:0] sync threshold Y.
  - 0x0C BURST: [15:0] burst count B.
  - 0x10 STATUS (read-only): bit0 active, bit1 done, [31:16] completed-period count.
  - 0x20 + 4k: OFFSET k, [SYNCW-1:0], for k < CHANNELS.
- Unmapped reads return 0. Unmapped and read-only writes are ignored. Unused register bits read 0.
- Start condition: rising edge of CTRL.EN while inactive.
  - Sets active.
  - Pulses start for one cycle.
  - Clears the subcycle counter, the sync counter, the burst count and done.
- Subcycle counter: while active it increments every clock. When the counter is ≥ S, assert subcycle for that cycle and reset the counter to 0 on the next cycle. The ≥ comparison keeps the counter from running past S when S is lowered live.
- Sync counter: advances on each subcycle. When it is ≥ Y it wraps to 0, and that wrap ends one sync period.
- Channel k: assert sync_o[k] in a subcycle cycle where the pre-increment sync counter equals OFFSET k. An offset greater than Y never fires.
- `wfg_subcore_subcycle_cnt_o` equals the sync counter value. It holds 0 while inactive.
- Burst mode: on each period end, increment the period count. When the count reaches max(B,1), on the next cycle clear active and set done.
- Continuous mode: the period count saturates at 0xFFFF and the generator never stops.
- EN cleared while active: on the next cycle active drops, counters clear and done is unchanged.
- Re-arm after a burst: EN must return to 0 and then 1. CLR_DONE clears done without starting the generator.
- S, Y and the offsets are used live while running. MODE and B are sampled at start.

## Timing
- Reset: every output and register is 0 and `wbs_ack_o` is 0.
- Wishbone ack:
  - Asserted the cycle after `stb&cyc` while ack is low, for exactly one cycle.
  - The write lands on the same edge that raises ack.
  - `wbs_dat_o` is valid while ack is high, otherwise 0.
  - Byte enables apply per byte.
- EN write to outputs: start and active assert on the cycle after ack (one register stage). This is cycle 0, and the subcycle counter is 0 in cycle 0.
- Pulse positions and periods:
  - Subcycle pulses fall at cycles S, 2S+1, … (period S+1).
  - Sync period is (S+1)(Y+1) clocks.
- S = 0: subcycle is asserted every active cycle.
- S = 0 and Y = 0 with OFFSET 0: sync_o[k] is high continuously while active.
- No combinational path from any input to any pulse output. All pulses are decoded from registered state only.
- Asynchronous reset mid-operation: everything returns to 0 immediately. There is no start pulse on reset release even if the bus holds EN stable.

## Test plan
- Reset and bus check: write 0xA5 to OFFSET0, then read it back. Read STATUS: expect 0. Check every output is 0 after `wb_rst_i` pulses.
- Continuous run: S=3, Y=2, OFFSET0=0, OFFSET1=2, EN=1. Expect:
  - start at cycle 0;
  - subcycle at cycles 3, 7, 11, 15;
  - sync_o[0] at cycles 3 and 15;
  - sync_o[1] at cycle 11;
  - subcycle_cnt 0, 1, 2, 0 across those pulses.
- Burst: MODE=1, B=2, S=3, Y=2. Expect:
  - the last subcycle at cycle 23;
  - active=0 and done=1 at cycle 24;
  - STATUS period count = 2.
- Disable mid-run: clear EN at cycle 9. Expect active=0 at the next cycle, counters 0 and done still 0. EN 0→1 then restarts with a start pulse.
- Live shrink: S=10, run to counter 7, write S=4. Expect subcycle on the next cycle, then period 5.
- Offset beyond Y: OFFSET2=5 with Y=2. Expect sync_o[2] never fires. CLR_DONE after a burst drops done with active still 0.
